// File: rtl/reg_status_file.sv
// Register status file: architectural data plus ROB producer tags.
// Three lookup ports with same-cycle commit bypass and a busy counter.
module reg_status_file #(
    parameter int REG_W  = 5,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rename_en,
    input  logic [REG_W-1:0]  rename_reg,
    input  logic [TAG_W-1:0]  rename_tag,
    input  logic              commit_en,
    input  logic [REG_W-1:0]  commit_reg,
    input  logic [DATA_W-1:0] commit_data,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic              flush,
    input  logic [REG_W-1:0]  rd_reg1,
    input  logic [REG_W-1:0]  rd_reg2,
    input  logic [REG_W-1:0]  rd_regd,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [DATA_W-1:0] rd_datad,
    output logic [TAG_W-1:0]  rd_tag1,
    output logic [TAG_W-1:0]  rd_tag2,
    output logic [TAG_W-1:0]  rd_tagd,
    output logic [REG_W:0]    busy_count
);

    localparam int NREG = 1 << REG_W;
    localparam int BW   = REG_W + 1;
    localparam logic [TAG_W-1:0] TAG_FREE =
        {1'b1, {(TAG_W-1){1'b0}}};

    logic [DATA_W-1:0] data_q [NREG];
    logic [TAG_W-1:0]  tag_q  [NREG];

    logic [REG_W-1:0]  lk_reg  [3];
    logic [DATA_W-1:0] lk_data [3];
    logic [TAG_W-1:0]  lk_tag  [3];

    assign lk_reg[0] = rd_reg1;
    assign lk_reg[1] = rd_reg2;
    assign lk_reg[2] = rd_regd;

    assign rd_data1 = lk_data[0];
    assign rd_data2 = lk_data[1];
    assign rd_datad = lk_data[2];
    assign rd_tag1  = lk_tag[0];
    assign rd_tag2  = lk_tag[1];
    assign rd_tagd  = lk_tag[2];

    // A retiring producer is visible to the decoder in the same cycle.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            lk_data[p] = data_q[lk_reg[p]];
            lk_tag[p]  = tag_q[lk_reg[p]];
            if (!rst || lk_reg[p] == '0) begin
                lk_data[p] = '0;
                lk_tag[p]  = TAG_FREE;
            end else if (commit_en
                         && commit_reg == lk_reg[p]
                         && tag_q[lk_reg[p]] == commit_tag) begin
                lk_data[p] = commit_data;
                lk_tag[p]  = TAG_FREE;
            end
        end
    end

    logic rename_ok;
    logic commit_ok;
    logic rel_ok;
    logic new_busy;

    assign rename_ok = rename_en && rename_reg != '0 && !flush;
    assign commit_ok = commit_en && commit_reg != '0;

    // A same-cycle rename of the retiring register keeps it busy.
    assign rel_ok = commit_ok
                 && tag_q[commit_reg] == commit_tag
                 && commit_tag != TAG_FREE
                 && !(rename_ok && rename_reg == commit_reg);

    assign new_busy = rename_ok
                   && tag_q[rename_reg] == TAG_FREE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= TAG_FREE;
            end
            busy_count <= '0;
        end else begin
            if (commit_ok)
                data_q[commit_reg] <= commit_data;
            if (flush) begin
                for (int i = 0; i < NREG; i++)
                    tag_q[i] <= TAG_FREE;
                busy_count <= '0;
            end else begin
                if (rel_ok)
                    tag_q[commit_reg] <= TAG_FREE;
                if (rename_ok)
                    tag_q[rename_reg] <= rename_tag;
                busy_count <= busy_count
                            + BW'(new_busy)
                            - BW'(rel_ok);
            end
        end
    end

endmodule

// File: tb/tb_reg_status_file.sv
// Bench for reg_status_file: directed vectors, literal checks and
// a per-cycle comparison against an architectural model.
module tb_reg_status_file;

    localparam logic [3:0] FREE = 4'b1000;

    logic        clk;
    logic        rst;
    logic        rename_en;
    logic [4:0]  rename_reg;
    logic [3:0]  rename_tag;
    logic        commit_en;
    logic [4:0]  commit_reg;
    logic [31:0] commit_data;
    logic [3:0]  commit_tag;
    logic        flush;
    logic [4:0]  rd_reg1;
    logic [4:0]  rd_reg2;
    logic [4:0]  rd_regd;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic [31:0] rd_datad;
    logic [3:0]  rd_tag1;
    logic [3:0]  rd_tag2;
    logic [3:0]  rd_tagd;
    logic [5:0]  busy_count;

    int checks = 0;
    int errors = 0;

    reg_status_file dut (
        .clk(clk), .rst(rst),
        .rename_en(rename_en), .rename_reg(rename_reg),
        .rename_tag(rename_tag),
        .commit_en(commit_en), .commit_reg(commit_reg),
        .commit_data(commit_data), .commit_tag(commit_tag),
        .flush(flush),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .rd_regd(rd_regd),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_datad(rd_datad),
        .rd_tag1(rd_tag1), .rd_tag2(rd_tag2), .rd_tagd(rd_tagd),
        .busy_count(busy_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Architectural model: per-register value and producer tag.
    logic [31:0] m_data [32];
    logic [3:0]  m_tag  [32];

    function automatic void m_clear();
        for (int i = 0; i < 32; i++) begin
            m_data[i] = 0;
            m_tag[i]  = FREE;
        end
    endfunction

    function automatic int m_busy();
        int n = 0;
        for (int i = 1; i < 32; i++)
            if (m_tag[i] != FREE) n++;
        return n;
    endfunction

    function automatic logic [35:0] m_look(logic [4:0] r);
        if (!rst || r == 0) return {FREE, 32'h0};
        if (commit_en && commit_reg == r
            && m_tag[r] == commit_tag)
            return {FREE, commit_data};
        return {m_tag[r], m_data[r]};
    endfunction

    always @(negedge rst) m_clear();

    always @(posedge clk) begin
        if (!rst) begin
            m_clear();
        end else begin
            logic [3:0] old_tag [32];
            logic       ren;
            old_tag = m_tag;
            ren = rename_en && rename_reg != 0;
            if (commit_en && commit_reg != 0)
                m_data[commit_reg] = commit_data;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_tag[i] = FREE;
            end else begin
                if (commit_en && commit_reg != 0
                    && old_tag[commit_reg] == commit_tag
                    && !(ren && rename_reg == commit_reg))
                    m_tag[commit_reg] = FREE;
                if (ren) m_tag[rename_reg] = rename_tag;
            end
        end
    end

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [35:0] e;
        e = m_look(rd_reg1);
        chk("cmp_tag1", 32'(rd_tag1), 32'(e[35:32]));
        chk("cmp_data1", rd_data1, e[31:0]);
        e = m_look(rd_reg2);
        chk("cmp_tag2", 32'(rd_tag2), 32'(e[35:32]));
        chk("cmp_data2", rd_data2, e[31:0]);
        e = m_look(rd_regd);
        chk("cmp_tagd", 32'(rd_tagd), 32'(e[35:32]));
        chk("cmp_datad", rd_datad, e[31:0]);
        chk("cmp_busy", 32'(busy_count), 32'(m_busy()));
    end

    task automatic idle();
        rename_en   = 0;
        rename_reg  = 0;
        rename_tag  = 0;
        commit_en   = 0;
        commit_reg  = 0;
        commit_data = 0;
        commit_tag  = 0;
        flush       = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic ren(logic [4:0] r, logic [3:0] t);
        rename_en  = 1;
        rename_reg = r;
        rename_tag = t;
    endtask

    task automatic cmt(logic [4:0] r, logic [3:0] t,
                       logic [31:0] d);
        commit_en   = 1;
        commit_reg  = r;
        commit_tag  = t;
        commit_data = d;
    endtask

    initial begin
        m_clear();
        rst = 0;
        idle();
        rd_reg1 = 5;
        rd_reg2 = 0;
        rd_regd = 0;
        #3;
        chk("rst_tag1", 32'(rd_tag1), 32'(FREE));
        chk("rst_data1", rd_data1, 0);
        chk("rst_busy", 32'(busy_count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1;
        tick();
        #1;
        chk("x5_tag_idle", 32'(rd_tag1), 32'(FREE));
        chk("x5_busy_idle", 32'(busy_count), 0);

        ren(5, 3);
        tick();
        #1;
        chk("x5_tag3", 32'(rd_tag1), 3);
        chk("x5_busy1", 32'(busy_count), 1);
        tick();
        cmt(5, 3, 32'hDEADBEEF);
        #1;
        chk("x5_byp_tag", 32'(rd_tag1), 32'(FREE));
        chk("x5_byp_data", rd_data1, 32'hDEADBEEF);
        tick();
        #1;
        chk("x5_busy0", 32'(busy_count), 0);
        chk("x5_data", rd_data1, 32'hDEADBEEF);

        rd_reg2 = 7;
        ren(7, 1);
        tick();
        ren(7, 2);
        tick();
        #1;
        chk("x7_busy1", 32'(busy_count), 1);
        cmt(7, 1, 32'h11);
        #1;
        chk("x7_nobyp_tag", 32'(rd_tag2), 2);
        tick();
        #1;
        chk("x7_data", rd_data2, 32'h11);
        chk("x7_tag2", 32'(rd_tag2), 2);
        chk("x7_busy", 32'(busy_count), 1);

        rd_regd = 9;
        ren(9, 0);
        tick();
        #1;
        chk("x9_busy2", 32'(busy_count), 2);
        ren(9, 4);
        cmt(9, 0, 32'h22);
        tick();
        #1;
        chk("x9_data", rd_datad, 32'h22);
        chk("x9_tag4", 32'(rd_tagd), 4);
        chk("x9_busy2b", 32'(busy_count), 2);

        ren(1, 5);
        tick();
        ren(2, 6);
        tick();
        ren(3, 7);
        tick();
        #1;
        chk("pre_flush_busy", 32'(busy_count), 5);
        ren(4, 1);
        flush = 1;
        rd_reg1 = 4;
        rd_reg2 = 1;
        tick();
        #1;
        chk("flush_busy", 32'(busy_count), 0);
        chk("flush_x4", 32'(rd_tag1), 32'(FREE));
        chk("flush_x1", 32'(rd_tag2), 32'(FREE));
        chk("flush_x9", 32'(rd_tagd), 32'(FREE));

        rd_reg1 = 0;
        ren(0, 2);
        cmt(0, 2, 32'h55);
        #1;
        chk("x0_byp_data", rd_data1, 0);
        tick();
        #1;
        chk("x0_data", rd_data1, 0);
        chk("x0_tag", 32'(rd_tag1), 32'(FREE));
        chk("x0_busy", 32'(busy_count), 0);

        rd_reg1 = 8;
        rd_reg2 = 5;
        ren(8, 3);
        tick();
        #1;
        chk("x8_tag3", 32'(rd_tag1), 3);
        chk("x8_busy1", 32'(busy_count), 1);
        chk("x5_kept", rd_data2, 32'hDEADBEEF);
        rst = 0;
        #1;
        chk("arst_x8_tag", 32'(rd_tag1), 32'(FREE));
        chk("arst_x5_data", rd_data2, 0);
        chk("arst_busy", 32'(busy_count), 0);
        @(negedge clk);
        #2 rst = 1;
        rd_reg1 = 6;
        ren(6, 2);
        tick();
        #1;
        chk("post_rst_tag", 32'(rd_tag1), 2);
        chk("post_rst_busy", 32'(busy_count), 1);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
